cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Controller for the small write-back cache used in the memory-hierarchy practicals.
- Accepts one CPU read or write at a time and looks it up in an internal 2-way set-associative tag/valid/dirty/LRU store with data.
- On a miss it sequences the next-level memory: a writeback strobe for a dirty victim, then a read strobe for the fill.
- Sits between the CPU-side request port and the backing memory block.

Parameters:
ADDR_W, 3, address width; tag = addr[ADDR_W-1:INDEX_W], index = addr[INDEX_W-1:0]
DATA_W, 3, data word width (one word per line)
INDEX_W, 1, index bits; number of sets is 2**INDEX_W; 2 ways per set

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  CPU request present
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  request address
req_wdata  input  DATA_W  write data
req_ready  output  1  controller can accept; high only in IDLE
resp_valid  output  1  one-cycle pulse; request complete
resp_data  output  DATA_W  read data, or written data for writes; valid with resp_valid
resp_hit  output  1  1 if the request hit in LOOKUP; valid with resp_valid
mem_read  output  1  one-cycle fill strobe
mem_addr  output  ADDR_W  fill address
mem_wb  output  1  one-cycle writeback strobe
mem_wb_addr  output  ADDR_W  victim address {victim tag, index}
mem_wb_data  output  DATA_W  victim data
mem_rdata  input  DATA_W  fill data; valid when mem_ready is high in FILL_WAIT
mem_ready  input  1  memory done; sampled only in WB_WAIT / FILL_WAIT

Behaviour:
- Reset (sync, active-high): state=IDLE; all valid, dirty and LRU bits cleared; every output 0 except req_ready=1. Reset mid-transaction abandons it: no resp_valid, and no further strobes are issued.
- Single outstanding request. A request is accepted on a clock edge where req_valid && req_ready; addr, we and wdata are latched.
- FSM: IDLE -> LOOKUP -> {RESPOND | WB_REQ | FILL_REQ}; WB_REQ -> WB_WAIT -> FILL_REQ; FILL_REQ -> FILL_WAIT -> RESPOND; RESPOND -> IDLE.
- LOOKUP, hit (valid and tag match):
  - Read returns the way data.
  - Write stores wdata and sets dirty.
  - The set's LRU bit points to the other way.
  - Next state RESPOND.
- LOOKUP, miss, victim selection: first invalid way, with way0 before way1; if both ways are valid, the LRU way. Dirty victim -> WB_REQ; otherwise -> FILL_REQ.
- WB_REQ: mem_wb=1 for exactly one cycle, with mem_wb_addr and mem_wb_data held stable from this cycle until WB_WAIT exits.
- WB_WAIT: stays until mem_ready=1, then goes to FILL_REQ.
- FILL_REQ: mem_read=1 for exactly one cycle, with mem_addr = latched address held stable through FILL_WAIT.
- FILL_WAIT: on mem_ready=1, installs the line:
  - tag and valid set; data = mem_rdata.
  - Write request: wdata overwrites the filled data and dirty=1. Read request: dirty=0.
  - LRU points away from the filled way.
  - Next state RESPOND.
- RESPOND: resp_valid=1 for one cycle with resp_data and resp_hit, then IDLE with req_ready=1.
- Latency from the accept edge:
  - Hit: resp_valid in the 2nd cycle.
  - Clean miss: 3 cycles + fill wait.
  - Dirty miss: 4 cycles + writeback wait + fill wait.
- mem_ready is ignored in every state except WB_WAIT and FILL_WAIT. mem_ready in the same cycle as a strobe is ignored; it is sampled from the following cycle onward.
- No timeout: the wait states hold indefinitely.
- All tag, data and address arithmetic is unsigned and fixed-width; no wrap cases arise.

Optional Feature:
CACHE_STATS_EN:
- When defined, adds outputs hit_count [7:0] and miss_count [7:0].
- Each counter increments once per LOOKUP by outcome, saturates at 255, and is cleared by reset.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- After reset, read addr 3'b101 with mem_ready returned 2 cycles after mem_read and mem_rdata=3'b011 -> one mem_read pulse with mem_addr=101; no mem_wb; resp_valid with resp_data=011, resp_hit=0.
- Repeat read 3'b101 -> resp_valid exactly 2 cycles after accept; resp_data=011, resp_hit=1; no memory strobes.
- Write 3'b010 to addr 3'b001 (miss, fill returns 3'b111) -> resp_data=010, resp_hit=0; a later read of 3'b001 hits with 010.
- Fill both ways of set 1 (addrs 001 and 011, 001 dirty), touch 011, then read 111 -> victim = LRU way holding 001: mem_wb with mem_wb_addr=001, mem_wb_data=010, then mem_read with mem_addr=111.
- Assert reset during FILL_WAIT -> next cycle req_ready=1, no resp_valid; a later mem_ready is ignored; the previously cached address now misses.
- With CACHE_STATS_EN defined, run the above sequence -> hit_count and miss_count match the expected per-LOOKUP tallies; forcing 300 hits -> hit_count=255.

Source files
------------

// File: rtl/cache_ctrl.sv
// Write-back cache controller: 2-way set-associative, one word per line, LRU replacement.
// Optional hit/miss statistics counters are enabled with `define CACHE_STATS_EN.
module cache_ctrl #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 3,
  parameter int INDEX_W = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wb,
  output logic [ADDR_W-1:0] mem_wb_addr,
  output logic [DATA_W-1:0] mem_wb_data,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef CACHE_STATS_EN
  output logic [7:0]        hit_count,
  output logic [7:0]        miss_count,
`endif
  input  logic              mem_ready
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RESPOND, S_WB_REQ, S_WB_WAIT, S_FILL_REQ, S_FILL_WAIT
  } state_t;

  state_t                     r_state;
  logic [SETS-1:0][1:0]       r_valid;
  logic [SETS-1:0][1:0]       r_dirty;
  logic [SETS-1:0]            r_lru;
  logic [TAG_W-1:0]           r_tag  [SETS][2];
  logic [DATA_W-1:0]          r_data [SETS][2];
  logic [ADDR_W-1:0]          r_addr;
  logic                       r_we;
  logic [DATA_W-1:0]          r_wdata;
  logic                       r_victim;
  logic                       r_req_ready, r_resp_valid, r_resp_hit, r_mem_read, r_mem_wb;
  logic [DATA_W-1:0]          r_resp_data, r_mem_wb_data;
  logic [ADDR_W-1:0]          r_mem_addr, r_mem_wb_addr;
`ifdef CACHE_STATS_EN
  logic [7:0]                 r_hit_count, r_miss_count;
`endif

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit0, w_hit1, w_hit, w_hit_way, w_victim;

  assign w_idx     = r_addr[INDEX_W-1:0];
  assign w_tag     = r_addr[ADDR_W-1:INDEX_W];
  assign w_hit0    = r_valid[w_idx][0] && (r_tag[w_idx][0] == w_tag);
  assign w_hit1    = r_valid[w_idx][1] && (r_tag[w_idx][1] == w_tag);
  assign w_hit     = w_hit0 || w_hit1;
  assign w_hit_way = w_hit1;
  // Invalid ways are filled first (way0 before way1); only a full set falls back to LRU.
  assign w_victim  = !r_valid[w_idx][0] ? 1'b0 :
                     !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_dirty       <= '0;
      r_lru         <= '0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_resp_hit    <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wb      <= 1'b0;
      r_mem_wb_addr <= '0;
      r_mem_wb_data <= '0;
`ifdef CACHE_STATS_EN
      r_hit_count   <= '0;
      r_miss_count  <= '0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_wb     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_we        <= req_we;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
`ifdef CACHE_STATS_EN
          if (w_hit) begin
            if (r_hit_count != 8'hFF) r_hit_count <= r_hit_count + 8'd1;
          end else if (r_miss_count != 8'hFF) begin
            r_miss_count <= r_miss_count + 8'd1;
          end
`endif
          if (w_hit) begin
            r_lru[w_idx] <= ~w_hit_way;
            if (r_we) begin
              r_data[w_idx][w_hit_way]  <= r_wdata;
              r_dirty[w_idx][w_hit_way] <= 1'b1;
              r_resp_data               <= r_wdata;
            end else begin
              r_resp_data <= r_data[w_idx][w_hit_way];
            end
            r_resp_hit   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESPOND;
          end else begin
            r_victim   <= w_victim;
            r_resp_hit <= 1'b0;
            if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
              r_mem_wb_addr <= {r_tag[w_idx][w_victim], w_idx};
              r_mem_wb_data <= r_data[w_idx][w_victim];
              r_mem_wb      <= 1'b1;
              r_state       <= S_WB_REQ;
            end else begin
              r_mem_addr <= r_addr;
              r_mem_read <= 1'b1;
              r_state    <= S_FILL_REQ;
            end
          end
        end
        S_WB_REQ: r_state <= S_WB_WAIT;
        S_WB_WAIT: begin
          if (mem_ready) begin
            r_mem_addr <= r_addr;
            r_mem_read <= 1'b1;
            r_state    <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: r_state <= S_FILL_WAIT;
        S_FILL_WAIT: begin
          if (mem_ready) begin
            r_tag[w_idx][r_victim]   <= w_tag;
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= r_we;
            r_data[w_idx][r_victim]  <= r_we ? r_wdata : mem_rdata;
            r_lru[w_idx]             <= ~r_victim;
            r_resp_data              <= r_we ? r_wdata : mem_rdata;
            r_resp_valid             <= 1'b1;
            r_state                  <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign resp_hit    = r_resp_hit;
  assign mem_read    = r_mem_read;
  assign mem_addr    = r_mem_addr;
  assign mem_wb      = r_mem_wb;
  assign mem_wb_addr = r_mem_wb_addr;
  assign mem_wb_data = r_mem_wb_data;
`ifdef CACHE_STATS_EN
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: vector table with a response scoreboard, plus reset-abort and
// statistics-saturation sequences (the latter only when CACHE_STATS_EN is defined).
module tb_cache_ctrl;
  logic       clock = 1'b0;
  logic       reset, req_valid, req_we, mem_ready;
  logic [2:0] req_addr, req_wdata, mem_rdata;
  logic       req_ready, resp_valid, resp_hit, mem_read, mem_wb;
  logic [2:0] resp_data, mem_addr, mem_wb_addr, mem_wb_data;
`ifdef CACHE_STATS_EN
  logic [7:0] hit_count, miss_count;
`endif

  int total = 0;
  int bad   = 0;

  cache_ctrl #(.ADDR_W(3), .DATA_W(3), .INDEX_W(1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_wb(mem_wb),
    .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data), .mem_rdata(mem_rdata),
`ifdef CACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       we;
    logic [2:0] addr, wdata, fill;
    int         dfill;
    logic       wb;
    logic [2:0] wb_addr, wb_data;
    int         dwb;
    logic [2:0] exp_data;
    logic       exp_hit;
  } vec_t;

  typedef struct {
    logic [2:0] d;
    logic       h;
    int         lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] addr, input logic [2:0] wdata,
                              input logic [2:0] fill, input int dfill, input logic wb,
                              input logic [2:0] wb_addr, input logic [2:0] wb_data, input int dwb,
                              input logic [2:0] d, input logic h);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.fill = fill; v.dfill = dfill;
    v.wb = wb; v.wb_addr = wb_addr; v.wb_data = wb_data; v.dwb = dwb;
    v.exp_data = d; v.exp_hit = h;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the response.
  task automatic run_txn(input vec_t v);
    int   cyc, due_wb, due_fill, n_wb, n_rd;
    bit   done;
    exp_t e;
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    e.d = v.exp_data;
    e.h = v.exp_hit;
    e.lat = v.exp_hit ? 2 : (v.wb ? 4 + v.dwb + v.dfill : 3 + v.dfill);
    sb.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
    cyc = 1; due_wb = -1; due_fill = -1; n_wb = 0; n_rd = 0; done = 0;
    while (!done && cyc < 200) begin
      mem_ready = 1'b0;
      if (cyc == due_wb) begin
        chk("wb_addr_hold", 32'(mem_wb_addr), 32'(v.wb_addr));
        mem_ready = 1'b1;
      end
      if (cyc == due_fill) begin
        chk("fill_addr_hold", 32'(mem_addr), 32'(v.addr));
        mem_ready = 1'b1;
        mem_rdata = v.fill;
      end
      // Strobe cycles also raise mem_ready with junk data; the controller must ignore it.
      if (mem_wb) begin
        n_wb++;
        chk("wb_addr", 32'(mem_wb_addr), 32'(v.wb_addr));
        chk("wb_data", 32'(mem_wb_data), 32'(v.wb_data));
        due_wb = cyc + v.dwb;
        mem_ready = 1'b1;
        mem_rdata = ~v.fill;
      end
      if (mem_read) begin
        n_rd++;
        chk("fill_addr", 32'(mem_addr), 32'(v.addr));
        due_fill = cyc + v.dfill;
        mem_ready = 1'b1;
        mem_rdata = ~v.fill;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          chk("resp_data", 32'(resp_data), 32'(e.d));
          chk("resp_hit", 32'(resp_hit), 32'(e.h));
          chk("resp_latency", 32'(cyc), 32'(e.lat));
        end
        done = 1;
      end
      @(negedge clock);
      cyc++;
    end
    mem_ready = 1'b0;
    chk("resp_timeout", 32'(done), 1);
    chk("resp_pulse_width", 32'(resp_valid), 0);
    chk("wb_strobes", 32'(n_wb), 32'(v.wb));
    chk("fill_strobes", 32'(n_rd), v.exp_hit ? 32'd0 : 32'd1);
  endtask

  initial begin
    int  seen, act;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    //             we    addr    wdata   fill  df  wb    wbaddr  wbdata dwb  data    hit
    tbl[0]  = mk(1'b0, 3'b101, 3'b000, 3'b011, 2, 1'b0, 3'b000, 3'b000, 1, 3'b011, 1'b0);
    tbl[1]  = mk(1'b0, 3'b101, 3'b000, 3'b000, 1, 1'b0, 3'b000, 3'b000, 1, 3'b011, 1'b1);
    tbl[2]  = mk(1'b1, 3'b001, 3'b010, 3'b111, 1, 1'b0, 3'b000, 3'b000, 1, 3'b010, 1'b0);
    tbl[3]  = mk(1'b0, 3'b001, 3'b000, 3'b000, 1, 1'b0, 3'b000, 3'b000, 1, 3'b010, 1'b1);
    tbl[4]  = mk(1'b0, 3'b011, 3'b000, 3'b100, 3, 1'b0, 3'b000, 3'b000, 1, 3'b100, 1'b0);
    tbl[5]  = mk(1'b0, 3'b011, 3'b000, 3'b000, 1, 1'b0, 3'b000, 3'b000, 1, 3'b100, 1'b1);
    tbl[6]  = mk(1'b0, 3'b111, 3'b000, 3'b110, 2, 1'b1, 3'b001, 3'b010, 2, 3'b110, 1'b0);
    tbl[7]  = mk(1'b0, 3'b111, 3'b000, 3'b000, 1, 1'b0, 3'b000, 3'b000, 1, 3'b110, 1'b1);
    tbl[8]  = mk(1'b0, 3'b001, 3'b000, 3'b101, 1, 1'b0, 3'b000, 3'b000, 1, 3'b101, 1'b0);
    tbl[9]  = mk(1'b1, 3'b000, 3'b110, 3'b001, 1, 1'b0, 3'b000, 3'b000, 1, 3'b110, 1'b0);
    tbl[10] = mk(1'b1, 3'b100, 3'b011, 3'b010, 2, 1'b0, 3'b000, 3'b000, 1, 3'b011, 1'b0);
    tbl[11] = mk(1'b0, 3'b110, 3'b000, 3'b111, 1, 1'b1, 3'b000, 3'b110, 3, 3'b111, 1'b0);
    tbl[12] = mk(1'b1, 3'b100, 3'b101, 3'b000, 1, 1'b0, 3'b000, 3'b000, 1, 3'b101, 1'b1);

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_wb", 32'(mem_wb), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wb_addr", 32'(mem_wb_addr), 0);
`ifdef CACHE_STATS_EN
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_miss_count", 32'(miss_count), 0);
`endif

    for (int i = 0; i < 13; i++) run_txn(tbl[i]);
`ifdef CACHE_STATS_EN
    chk("hit_count_seq", 32'(hit_count), 5);
    chk("miss_count_seq", 32'(miss_count), 8);
`endif

    // Reset while waiting for a fill: the transaction must vanish without a trace.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'b010;
    @(negedge clock);
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (mem_read) seen = 1;
      else @(negedge clock);
    end
    chk("abort_fill_strobe", 32'(seen), 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_req_ready", 32'(req_ready), 1);
    chk("abort_resp_valid", 32'(resp_valid), 0);
    chk("abort_mem_read", 32'(mem_read), 0);
`ifdef CACHE_STATS_EN
    chk("abort_hit_count", 32'(hit_count), 0);
`endif
    mem_ready = 1'b1; mem_rdata = 3'b010;
    @(negedge clock);
    mem_ready = 1'b0;
    act = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid || mem_read || mem_wb || !req_ready) act++;
      @(negedge clock);
    end
    chk("abort_quiet", 32'(act), 0);
    run_txn(mk(1'b0, 3'b100, 3'b000, 3'b011, 1, 1'b0, 3'b000, 3'b000, 1, 3'b011, 1'b0));

`ifdef CACHE_STATS_EN
    for (int i = 0; i < 300; i++)
      run_txn(mk(1'b0, 3'b100, 3'b000, 3'b000, 1, 1'b0, 3'b000, 3'b000, 1, 3'b011, 1'b1));
    chk("hit_count_sat", 32'(hit_count), 255);
    chk("miss_count_after", 32'(miss_count), 1);
`endif

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
